// File: rtl/fpu_wb_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_wb_arbiter
//
// Write-back arbiter for the FPU pipeline's single register-file write port.
// Each result producer (add, multiply, divide, load, ...) hands over a
// destination register and a 32-bit result through a valid/ready handshake.
// The arbiter keeps one holding buffer per producer. Each cycle it grants the
// write port to at most one occupied buffer. The write-back outputs are
// registered, so they change on the rising edge and are stable for the
// register file's falling-edge write.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   req_valid  per requester: a result is presented
//   req_rd     per requester: 5-bit destination, requester i in [5i+4:5i]
//   req_value  per requester: 32-bit result, requester i in [32i+31:32i]
//   req_ready  per requester: the holding buffer can accept this cycle
//   wb_write   register-file write enable (registered)
//   wb_rd      register-file destination index (registered)
//   wb_value   register-file write data (registered)
//   wb_gid     index of the requester being written back (registered)
//   busy       at least one holding buffer is occupied
//
// Build option:
//   WB_ARB_FIXED_PRIO_EN  when defined, round-robin is replaced by fixed
//                         priority: the lowest occupied index always wins and
//                         no rotating pointer exists. A busy low-index
//                         requester can starve higher ones, so this build is
//                         meant for debug and deterministic tracing only.
// ---------------------------------------------------------------------------
module fpu_wb_arbiter #(
   parameter int N_REQ = 4,
   parameter int GID_W = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [5*N_REQ-1:0]    req_rd,
   input  logic [32*N_REQ-1:0]   req_value,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  wb_write,
   output logic [4:0]            wb_rd,
   output logic [31:0]           wb_value,
   output logic [GID_W-1:0]      wb_gid,
   output logic                  busy
);

   // Holding buffers, one per requester
   logic [N_REQ-1:0]  hold_valid_q;
   logic [N_REQ-1:0]  hold_valid_d;
   logic [4:0]        hold_rd_q    [N_REQ];
   logic [4:0]        hold_rd_d    [N_REQ];
   logic [31:0]       hold_value_q [N_REQ];
   logic [31:0]       hold_value_d [N_REQ];

   // Arbitration result for the current cycle
   logic [N_REQ-1:0]  grant;
   logic [N_REQ-1:0]  accept;
   logic              gnt_any;
   logic [GID_W-1:0]  gnt_idx;

   // Write-back output register
   logic              wb_write_q;
   logic              wb_write_d;
   logic [4:0]        wb_rd_q;
   logic [4:0]        wb_rd_d;
   logic [31:0]       wb_value_q;
   logic [31:0]       wb_value_d;
   logic [GID_W-1:0]  wb_gid_q;
   logic [GID_W-1:0]  wb_gid_d;

   // A buffer can take new data when it is empty, or when it is being
   // drained by this cycle's grant. This looks only at internal state, never
   // at req_valid, so no combinational path runs from valid to ready.
   assign req_ready = ~hold_valid_q | grant;
   assign accept    = req_valid & req_ready;
   assign busy      = |hold_valid_q;

`ifdef WB_ARB_FIXED_PRIO_EN

   // Fixed priority: scan from index 0 upward and grant the first occupied
   // buffer. No pointer is kept, so the winner depends only on which buffers
   // are occupied.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      grant   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!gnt_any && hold_valid_q[k]) begin
            gnt_any = 1'b1;
            gnt_idx = GID_W'(k);
         end
      end
      if (gnt_any) begin
         grant[gnt_idx] = 1'b1;
      end
   end

`else

   logic [GID_W-1:0]  ptr_q;
   logic [GID_W-1:0]  ptr_d;
   int                search_pos;
   logic [GID_W-1:0]  search_idx;

   // Round-robin: start the scan at ptr and walk toward higher indices,
   // wrapping after N_REQ-1. The first occupied buffer met is granted.
   // The modulo keeps the index legal when N_REQ is not a power of two.
   always_comb begin
      gnt_any    = 1'b0;
      gnt_idx    = '0;
      grant      = '0;
      search_pos = 0;
      search_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         search_pos = (int'(ptr_q) + k) % N_REQ;
         search_idx = GID_W'(search_pos);
         if (!gnt_any && hold_valid_q[search_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = search_idx;
         end
      end
      if (gnt_any) begin
         grant[gnt_idx] = 1'b1;
      end
   end

   // The pointer moves to the slot just past the winner, so the winner
   // becomes lowest priority next cycle. With nothing granted it holds.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         ptr_d = GID_W'((int'(gnt_idx) + 1) % N_REQ);
      end
   end

   // Pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

`endif

   // Next state of every holding buffer. An accept always loads new data and
   // marks the buffer full. This also covers the case where the buffer is
   // granted on the same edge, since the old data leaves through the
   // write-back register. A grant with no accept empties the buffer.
   // Otherwise the buffer holds, so a stalled requester's data stays put.
   always_comb begin
      hold_valid_d = hold_valid_q;
      for (int i = 0; i < N_REQ; i++) begin
         hold_rd_d[i]    = hold_rd_q[i];
         hold_value_d[i] = hold_value_q[i];
         if (accept[i]) begin
            hold_valid_d[i] = 1'b1;
            hold_rd_d[i]    = req_rd[5*i +: 5];
            hold_value_d[i] = req_value[32*i +: 32];
         end else if (grant[i]) begin
            hold_valid_d[i] = 1'b0;
         end
      end
   end

   // Holding buffer registers. Reset discards every buffered result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid_q <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            hold_rd_q[i]    <= '0;
            hold_value_q[i] <= '0;
         end
      end else begin
         hold_valid_q <= hold_valid_d;
         for (int i = 0; i < N_REQ; i++) begin
            hold_rd_q[i]    <= hold_rd_d[i];
            hold_value_q[i] <= hold_value_d[i];
         end
      end
   end

   // Write-back data. The enable follows the grant every cycle. The data
   // fields load only on a grant and otherwise keep their last values, so
   // the write port's data lines stay quiet while idle.
   always_comb begin
      wb_write_d = gnt_any;
      wb_rd_d    = wb_rd_q;
      wb_value_d = wb_value_q;
      wb_gid_d   = wb_gid_q;
      if (gnt_any) begin
         wb_rd_d    = hold_rd_q[gnt_idx];
         wb_value_d = hold_value_q[gnt_idx];
         wb_gid_d   = gnt_idx;
      end
   end

   // Write-back register. The asynchronous reset drops wb_write at once,
   // so the register file sees no write after reset is raised, even
   // partway through a cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_write_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_value_q <= '0;
         wb_gid_q   <= '0;
      end else begin
         wb_write_q <= wb_write_d;
         wb_rd_q    <= wb_rd_d;
         wb_value_q <= wb_value_d;
         wb_gid_q   <= wb_gid_d;
      end
   end

   assign wb_write = wb_write_q;
   assign wb_rd    = wb_rd_q;
   assign wb_value = wb_value_q;
   assign wb_gid   = wb_gid_q;

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_wb_arbiter
//
// Directed testbench for fpu_wb_arbiter with four requesters. Inputs are
// driven just after a rising edge. Outputs are sampled 1 time unit after the
// rising edge, which is well away from either clock edge. Expected values are
// worked out by hand for each scenario. Where WB_ARB_FIXED_PRIO_EN changes the
// grant order, both expectations are given.
// ---------------------------------------------------------------------------
module tb_fpu_wb_arbiter;

   localparam int N_REQ = 4;
   localparam int GID_W = 2;

   logic                  clk;
   logic                  rst;
   logic [N_REQ-1:0]      req_valid;
   logic [5*N_REQ-1:0]    req_rd;
   logic [32*N_REQ-1:0]   req_value;
   logic [N_REQ-1:0]      req_ready;
   logic                  wb_write;
   logic [4:0]            wb_rd;
   logic [31:0]           wb_value;
   logic [GID_W-1:0]      wb_gid;
   logic                  busy;

   int checkCount = 0;
   int errorCount = 0;

   fpu_wb_arbiter #(
      .N_REQ (N_REQ),
      .GID_W (GID_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_rd    (req_rd),
      .req_value (req_value),
      .req_ready (req_ready),
      .wb_write  (wb_write),
      .wb_rd     (wb_rd),
      .wb_value  (wb_value),
      .wb_gid    (wb_gid),
      .busy      (busy)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkWb(input string tag, input int wr, input int rd,
                          input int value, input int gid);
      checkOutput({tag, " wb_write"}, 32'(wb_write), wr);
      checkOutput({tag, " wb_rd"},    32'(wb_rd),    rd);
      checkOutput({tag, " wb_value"}, wb_value,      value);
      checkOutput({tag, " wb_gid"},   32'(wb_gid),   gid);
   endtask

   task automatic applyStimulus(input logic [N_REQ-1:0] valid);
      req_valid = valid;
   endtask

   task automatic setLane(input int idx, input logic [4:0] rd, input logic [31:0] value);
      req_rd[5*idx +: 5]      = rd;
      req_value[32*idx +: 32] = value;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset between edges. Called at rising edge + 1.
   task automatic pulseReset();
      applyStimulus('0);
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_rd    = '0;
      req_value = '0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      checkWb("reset", 0, 0, 0, 0);
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset req_ready", 32'(req_ready), 'hF);

      // Single requester, back to back
      applyStimulus(4'b0001);
      setLane(0, 5'd5, 32'd500);
      tick();
      checkOutput("t1 no write yet", 32'(wb_write), 0);
      checkOutput("t1 busy", 32'(busy), 1);
      checkOutput("t1 ready after accept", 32'(req_ready), 'hF);
      setLane(0, 5'd6, 32'd600);
      tick();
      checkWb("t1 first", 1, 5, 500, 0);
      checkOutput("t1 ready while streaming", 32'(req_ready), 'hF);
      setLane(0, 5'd7, 32'd700);
      tick();
      checkWb("t1 second", 1, 6, 600, 0);
      applyStimulus('0);
      tick();
      checkWb("t1 third", 1, 7, 700, 0);
      checkOutput("t1 busy drained", 32'(busy), 0);
      tick();
      checkWb("t1 idle hold", 0, 7, 700, 0);

      // All requesters at once
      pulseReset();
      applyStimulus(4'b1111);
      for (int i = 0; i < N_REQ; i++) setLane(i, 5'(i + 1), 32'(100 * (i + 1)));
      tick();
      applyStimulus('0);
      checkOutput("t2 ready after load", 32'(req_ready), 'h1);
      tick();
      checkWb("t2 grant0", 1, 1, 100, 0);
      checkOutput("t2 ready g0", 32'(req_ready), 'h3);
      tick();
      checkWb("t2 grant1", 1, 2, 200, 1);
      checkOutput("t2 ready g1", 32'(req_ready), 'h7);
      tick();
      checkWb("t2 grant2", 1, 3, 300, 2);
      checkOutput("t2 ready g2", 32'(req_ready), 'hF);
      tick();
      checkWb("t2 grant3", 1, 4, 400, 3);
      tick();
      checkOutput("t2 done write", 32'(wb_write), 0);
      checkOutput("t2 done busy", 32'(busy), 0);

      // Round-robin fairness (pointer is back at 0 after the last test)
      applyStimulus(4'b0101);
      setLane(0, 5'd10, 32'd1000);
      setLane(2, 5'd20, 32'd2000);
      tick();
      checkOutput("t3 ready after load", 32'(req_ready), 'hB);
      applyStimulus(4'b0001);
      setLane(0, 5'd11, 32'd1100);
      tick();
      checkWb("t3 grant a", 1, 10, 1000, 0);
`ifdef WB_ARB_FIXED_PRIO_EN
      checkOutput("t3 fixed ready", 32'(req_ready), 'hB);
      setLane(0, 5'd12, 32'd1200);
      tick();
      checkWb("t3 fixed b", 1, 11, 1100, 0);
      applyStimulus('0);
      tick();
      checkWb("t3 fixed c", 1, 12, 1200, 0);
      tick();
      checkWb("t3 fixed d", 1, 20, 2000, 2);
`else
      checkOutput("t3 rr ready stall0", 32'(req_ready), 'hE);
      setLane(0, 5'd12, 32'd1200);
      tick();
      checkWb("t3 rr b", 1, 20, 2000, 2);
      checkOutput("t3 rr ready", 32'(req_ready), 'hF);
      tick();
      checkWb("t3 rr c", 1, 11, 1100, 0);
      applyStimulus('0);
      tick();
      checkWb("t3 rr d", 1, 12, 1200, 0);
`endif
      tick();
      checkOutput("t3 done write", 32'(wb_write), 0);

      // Backpressure
      pulseReset();
      applyStimulus(4'b0011);
      setLane(0, 5'd1, 32'd11);
      setLane(1, 5'd2, 32'd22);
      tick();
      checkOutput("t4 ready stall1", 32'(req_ready), 'hD);
      applyStimulus(4'b0010);
      setLane(1, 5'd9, 32'd99);
      #1;
      checkOutput("t4 ready1 low", 32'(req_ready[1]), 0);
      tick();
      checkWb("t4 grant0", 1, 1, 11, 0);
      checkOutput("t4 ready1 on grant", 32'(req_ready), 'hF);
      tick();
      checkWb("t4 held data", 1, 2, 22, 1);
      applyStimulus('0);
      tick();
      checkWb("t4 new data", 1, 9, 99, 1);
      tick();
      checkOutput("t4 done write", 32'(wb_write), 0);

      // Reset mid-operation
      pulseReset();
      applyStimulus(4'b0111);
      setLane(0, 5'd3, 32'd30);
      setLane(1, 5'd4, 32'd40);
      setLane(2, 5'd5, 32'd50);
      tick();
      applyStimulus('0);
      tick();
      checkWb("t5 before reset", 1, 3, 30, 0);
      checkOutput("t5 busy before", 32'(busy), 1);
      #2;
      rst = 1'b1;
      #1;
      checkWb("t5 in reset", 0, 0, 0, 0);
      checkOutput("t5 busy in reset", 32'(busy), 0);
      checkOutput("t5 ready in reset", 32'(req_ready), 'hF);
      rst = 1'b0;
      tick();
      checkOutput("t5 post 1", 32'(wb_write), 0);
      tick();
      checkOutput("t5 post 2", 32'(wb_write), 0);
      applyStimulus(4'b0010);
      setLane(1, 5'd17, 32'd170);
      tick();
      applyStimulus('0);
      checkOutput("t5 no early write", 32'(wb_write), 0);
      tick();
      checkWb("t5 new accept", 1, 17, 170, 1);

      // Idle for 10 cycles, then the grant order shows the pointer held
      for (int c = 0; c < 10; c++) begin
         tick();
         checkOutput("t6 idle write", 32'(wb_write), 0);
      end
      checkWb("t6 idle hold", 0, 17, 170, 1);
      applyStimulus(4'b1111);
      for (int i = 0; i < N_REQ; i++) setLane(i, 5'(21 + i), 32'(210 + 10 * i));
      tick();
      applyStimulus('0);
`ifdef WB_ARB_FIXED_PRIO_EN
      tick(); checkWb("t6 order a", 1, 21, 210, 0);
      tick(); checkWb("t6 order b", 1, 22, 220, 1);
      tick(); checkWb("t6 order c", 1, 23, 230, 2);
      tick(); checkWb("t6 order d", 1, 24, 240, 3);
`else
      tick(); checkWb("t6 order a", 1, 23, 230, 2);
      tick(); checkWb("t6 order b", 1, 24, 240, 3);
      tick(); checkWb("t6 order c", 1, 21, 210, 0);
      tick(); checkWb("t6 order d", 1, 22, 220, 1);
`endif
      tick();
      checkOutput("t6 done write", 32'(wb_write), 0);
      checkOutput("t6 done busy", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
